// File: rtl/regfile.sv
// 32 x WIDTH register file with two combinational read ports, one clocked
// write port, a debug read port and a count of effective writes.
// Register 0 is not stored and always reads as zero.
module regfile #(
    parameter int unsigned WIDTH  = 32,
    parameter bit          BYPASS = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       raddr1,
    output logic [WIDTH-1:0] rdata1,
    input  logic [4:0]       raddr2,
    output logic [WIDTH-1:0] rdata2,
    input  logic             we,
    input  logic [4:0]       waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [4:0]       dbg_addr,
    output logic [WIDTH-1:0] dbg_data,
    output logic [31:0]      wr_count
);

    localparam int unsigned NREGS = 32;
    localparam int unsigned CW    = 32;

    logic [WIDTH-1:0] mem [1:NREGS-1];
    logic [CW-1:0]    count_q;
    logic             wr_hit_c;
    logic             fwd_en_c;

    // A write is effective only when enabled and not targeting register 0.
    always_comb begin
        wr_hit_c = we && (waddr != 5'd0);
    end

    // Array and write counter; reset has priority and discards any write.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 1; i < NREGS; i++) begin
                mem[i] <= '0;
            end
            count_q <= '0;
        end else if (wr_hit_c) begin
            mem[waddr] <= wdata;
            count_q    <= count_q + CW'(1);
        end
    end

    // Combinational reads; operand ports forward the in-flight write when enabled.
    always_comb begin
        fwd_en_c = BYPASS && !rst && wr_hit_c;
        rdata1   = '0;
        rdata2   = '0;
        dbg_data = '0;
        if (raddr1 != 5'd0) begin
            rdata1 = (fwd_en_c && (waddr == raddr1)) ? wdata : mem[raddr1];
        end
        if (raddr2 != 5'd0) begin
            rdata2 = (fwd_en_c && (waddr == raddr2)) ? wdata : mem[raddr2];
        end
        if (dbg_addr != 5'd0) begin
            dbg_data = mem[dbg_addr];
        end
    end

    assign wr_count = count_q;

endmodule
